// File: rtl/seg7_pkg.sv
// Shared constants for the 8-digit seven-segment scan driver.
// Latency: n/a (constants and a helper function only).
// Backpressure: n/a.
package seg7_pkg;

    localparam int N_DIGITS = 8;

    // Segment bit positions within the gfedcba vector.
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;
    localparam int N_SEG = SEG_G - SEG_A + 1;

    localparam logic [N_SEG-1:0] SEG_OFF = '0;

    // Active-high gfedcba patterns for hex digits 0..F.
    localparam logic [N_SEG-1:0] HEX_SEG [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [N_DIGITS-1:0] digit_onehot(input logic [2:0] idx);
        digit_onehot      = '0;
        digit_onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-high gfedcba segment decoder with blanking.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0]       nibble,
    input  logic             blank,
    output logic [N_SEG-1:0] seg
);

    always_comb begin
        seg = HEX_SEG[nibble];
        if (blank) begin
            seg = SEG_OFF;
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit hex display driver with tear-free frame-boundary update.
// Latency: an/seg/frame update 1 cycle after each prescaler tick; ack 1 cycle after commit.
// Backpressure: none; a load always lands in the shadow register, last value wins.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned CLK_DIV    = 50000,
    parameter bit          BLANK_LZ   = 1'b1,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         value,
    input  logic                load,
    output logic                ack,
    output logic [N_DIGITS-1:0] an,
    output logic [N_SEG-1:0]    seg,
    output logic                dp,
    output logic                frame
);

    localparam int            PW      = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);
    localparam logic [2:0]    IDX_LAST = 3'(N_DIGITS - 1);

    logic [PW-1:0]       ps_cnt;
    logic [2:0]          idx;
    logic [31:0]         disp;
    logic [31:0]         shadow;
    logic                pending;

    logic                tick;
    logic                wrap;
    logic                commit;
    logic [2:0]          idx_nxt;
    logic [31:0]         disp_nxt;
    logic [3:0]          nib_nxt;
    logic [N_DIGITS-1:0] hi_zero;
    logic                blank_nxt;
    logic [N_SEG-1:0]    seg_nxt;

    assign tick     = (ps_cnt == PS_LAST);
    assign wrap     = tick && (idx == IDX_LAST);
    assign commit   = wrap && pending;
    assign idx_nxt  = idx + 3'd1;

    // Outputs are computed from the post-commit image so a frame never mixes old and new digits.
    assign disp_nxt = commit ? shadow : disp;
    assign nib_nxt  = disp_nxt[{idx_nxt, 2'b00} +: 4];

    always_comb begin
        hi_zero = '0;
        for (int k = 0; k < N_DIGITS; k++) begin
            hi_zero[k] = ~|(disp_nxt >> (4 * k));
        end
    end

    assign blank_nxt = BLANK_LZ && (idx_nxt != 3'd0) && hi_zero[idx_nxt];

    seg7_decode u_decode (
        .nibble (nib_nxt),
        .blank  (blank_nxt),
        .seg    (seg_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps_cnt <= '0;
            idx    <= '0;
        end else if (tick) begin
            ps_cnt <= '0;
            idx    <= idx_nxt;
        end else begin
            ps_cnt <= ps_cnt + 1'b1;
        end
    end

    // A load coinciding with a commit refills the shadow, so pending stays set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow  <= '0;
            pending <= 1'b0;
            disp    <= '0;
            ack     <= 1'b0;
        end else begin
            ack <= commit;
            if (commit) begin
                disp <= shadow;
            end
            if (load) begin
                shadow  <= value;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            an    <= {N_DIGITS{ACTIVE_LOW}};
            seg   <= {N_SEG{ACTIVE_LOW}};
            frame <= 1'b0;
        end else if (tick) begin
            an    <= digit_onehot(idx_nxt) ^ {N_DIGITS{ACTIVE_LOW}};
            seg   <= seg_nxt ^ {N_SEG{ACTIVE_LOW}};
            frame <= wrap;
        end else begin
            frame <= 1'b0;
        end
    end

    assign dp = ACTIVE_LOW;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: reference model pushes expected scan steps and acks,
// monitors pop and compare whenever the DUT presents a new digit or an ack pulse.
module tb_seg7_scan_driver;

    localparam int CLK_DIV = 4;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] value = '0;
    logic        load  = 1'b0;
    logic        ack, dp, frame;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        ack2, dp2, frame2;
    logic [7:0]  an2;
    logic [6:0]  seg2;

    always #5 clk = ~clk;

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .value(value), .load(load),
        .ack(ack), .an(an), .seg(seg), .dp(dp), .frame(frame)
    );

    seg7_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0)) dut_nolz (
        .clk(clk), .reset(reset), .value(32'h0), .load(1'b0),
        .ack(ack2), .an(an2), .seg(seg2), .dp(dp2), .frame(frame2)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    logic [6:0] hex_ref [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef struct {
        int         digit;
        logic [6:0] seg;
        bit         frame;
    } scan_t;

    scan_t       scan_q[$];
    int          ack_q[$];
    int          cyc = 0;
    int          m_k = 0;      // clock edges since reset release
    int          m_t = 0;      // digit ticks since reset release
    logic [31:0] m_disp = '0;
    logic [31:0] m_shadow = '0;
    bit          m_pending = 1'b0;
    bit          m_tick, m_wrap;
    int          m_d;
    logic [31:0] m_hi;
    scan_t       m_s;

    always @(posedge clk) begin
        cyc++;
        if (!reset) begin
            m_k = 0; m_t = 0; m_disp = '0; m_shadow = '0; m_pending = 1'b0;
            scan_q.delete();
            ack_q.delete();
        end else begin
            m_tick = ((m_k % CLK_DIV) == CLK_DIV - 1);
            m_k++;
            if (m_tick) begin
                m_wrap = ((m_t % 8) == 7);
                m_t++;
                m_d = m_t % 8;
                if (m_wrap && m_pending) begin
                    m_disp    = m_shadow;
                    m_pending = 1'b0;
                    ack_q.push_back(cyc);
                end
                m_hi      = m_disp >> (4 * m_d);
                m_s.digit = m_d;
                m_s.frame = m_wrap;
                m_s.seg   = (m_d != 0 && m_hi == 0) ? 7'h00 : hex_ref[4'(m_hi & 32'hF)];
                scan_q.push_back(m_s);
            end
            if (load) begin
                m_shadow  = value;
                m_pending = 1'b1;
            end
        end
    end

    // ---------------- monitors ----------------
    logic [7:0] prev_an  = '0;
    logic [7:0] prev_an2 = '0;
    logic [7:0] seen2    = '0;
    int         frame_hi = 0;
    int         frames_seen = 0;
    int         acks_seen = 0;
    int         ack_exp;
    scan_t      got_s;

    always @(negedge clk) begin
        if (reset) begin
            if (an != prev_an && an != 8'h00) begin
                if (scan_q.size() == 0) begin
                    chk(1'b0, "scan_unexpected", {an, seg, frame}, 0);
                end else begin
                    got_s = scan_q.pop_front();
                    chk(an == (8'h01 << got_s.digit) && seg == got_s.seg && frame == got_s.frame,
                        "scan_an_seg_frame", {an, seg, frame},
                        {8'h01 << got_s.digit, got_s.seg, got_s.frame});
                    if (got_s.frame) frames_seen++;
                end
            end
            if (frame) frame_hi++;
            if (ack) begin
                acks_seen++;
                if (ack_q.size() == 0) begin
                    chk(1'b0, "ack_unexpected", cyc, 0);
                end else begin
                    ack_exp = ack_q.pop_front();
                    chk(cyc == ack_exp, "ack_cycle", cyc, ack_exp);
                end
            end
            if (an2 != prev_an2 && an2 != 8'h00) begin
                chk(seg2 == 7'h3F && $onehot(an2), "nolz_digit_zero", {an2, seg2}, {an2, 7'h3F});
                seen2 = seen2 | an2;
            end
        end
        prev_an  = an;
        prev_an2 = an2;
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    task automatic wait_digit(input int d);
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if ((m_t % 8) == d) hit = 1'b1;
        end
        if (!hit) chk(1'b0, "wait_digit_timeout", 0, 1);
    endtask

    // Returns just before the clock edge that wraps digit 7 -> 0.
    task automatic wait_commit_edge();
        bit hit = 1'b0;
        for (int i = 0; i < 200 && !hit; i++) begin
            step();
            if ((m_k % CLK_DIV) == CLK_DIV - 1 && (m_t % 8) == 7) hit = 1'b1;
        end
        if (!hit) chk(1'b0, "wait_commit_timeout", 0, 1);
    endtask

    task automatic chk_reset_outputs(input string name);
        @(negedge clk);
        chk(an == 8'h00 && seg == 7'h00 && dp == 1'b0 && ack == 1'b0 && frame == 1'b0 && an2 == 8'h00,
            name, {an, seg, dp, ack, frame, an2}, 0);
    endtask

    int a0;

    initial begin
        // reset state
        repeat (2) @(posedge clk);
        chk_reset_outputs("reset_outputs");
        step();
        reset = 1'b1;
        @(negedge clk);
        chk(an == 8'h00 && seg == 7'h00, "off_before_first_tick", {an, seg}, 0);
        step();

        // idle scan of an all-zero display
        repeat (40) step();

        // mid-frame load, visible only after the wrap
        wait_digit(3);
        a0 = acks_seen;
        do_load(32'h0000_12AF);
        repeat (80) step();
        chk(acks_seen - a0 == 1, "single_load_ack_count", acks_seen - a0, 1);

        // two loads in one frame: last one wins, one ack
        wait_digit(2);
        a0 = acks_seen;
        do_load(32'h1);
        wait_digit(4);
        do_load(32'h2);
        repeat (48) step();
        chk(acks_seen - a0 == 1, "double_load_ack_count", acks_seen - a0, 1);

        // load in the commit cycle
        wait_digit(3);
        a0 = acks_seen;
        do_load(32'h5);
        wait_commit_edge();
        do_load(32'hDEAD_BEEF);
        repeat (80) step();
        chk(acks_seen - a0 == 2, "collision_ack_count", acks_seen - a0, 2);

        // reset with a commit pending
        wait_digit(3);
        do_load(32'h0000_0077);
        wait_digit(5);
        a0 = acks_seen;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk_reset_outputs("reset_pulse_outputs");
            step();
        end
        reset = 1'b1;
        repeat (80) step();
        chk(acks_seen == a0, "no_ack_after_reset", acks_seen - a0, 0);

        // randomized loads, biased to small values to exercise blanking
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                value = $urandom_range(0, 1) ? $urandom : ($urandom >> (4 * $urandom_range(1, 7)));
                load  = 1'b1;
            end else begin
                load  = 1'b0;
            end
            step();
        end
        load = 1'b0;
        repeat (80) step();

        @(negedge clk);
        #1;
        chk(scan_q.size() == 0, "scan_queue_drained", scan_q.size(), 0);
        chk(ack_q.size() == 0, "ack_queue_drained", ack_q.size(), 0);
        chk(frames_seen > 0 && frame_hi == frames_seen, "frame_pulse_width", frame_hi, frames_seen);
        chk(seen2 == 8'hFF, "nolz_all_digits_seen", seen2, 8'hFF);
        chk(dp == 1'b0 && dp2 == 1'b0, "dp_off", {dp, dp2}, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
